// File: rtl/dac_sample_sequencer.sv
// dac_sample_sequencer: two-requester round-robin sample FIFO, rate-paced pop to an active-low DAC load strobe
module dac_sample_sequencer #(
  parameter int DEPTH = 4,
  parameter int RATE_W = 12
) (
  input  logic              XCK,
  input  logic              RESET,
  input  logic              EN,
  input  logic [RATE_W-1:0] RATE,
  input  logic              DSP_WR,
  input  logic [15:0]       DSP_D,
  output logic              DSP_ACK,
  input  logic              CPU_WR,
  input  logic [15:0]       CPU_D,
  output logic              CPU_ACK,
  output logic              FULL,
  output logic              EMPTY,
  output logic              UNDERRUN,
  input  logic              UNDERRUN_CLR,
  output logic              DACWRL,
  output logic [15:0]       DACD
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW:0] count, count_nx;
  logic [RATE_W-1:0] rate_cnt;
  logic prefer_cpu, tick, push, pop;
  logic [15:0] push_d;
  always_comb begin
    tick = EN && rate_cnt == '0;
    pop = tick && count != '0;
    push = count < DEPTH_C && (DSP_WR || CPU_WR);
    DSP_ACK = push && DSP_WR && (!CPU_WR || !prefer_cpu);
    CPU_ACK = push && !DSP_ACK;
    push_d = DSP_ACK ? DSP_D : CPU_D;
    count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end
  always_ff @(posedge XCK) begin
    if (RESET) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      FULL <= 1'b0;
      EMPTY <= 1'b1;
      UNDERRUN <= 1'b0;
      DACWRL <= 1'b1;
      DACD <= '0;
      rate_cnt <= RATE;
      prefer_cpu <= 1'b0;
    end else begin
      count <= count_nx;
      FULL <= count_nx == DEPTH_C;
      EMPTY <= count_nx == '0;
      rate_cnt <= (!EN || tick) ? RATE : rate_cnt - RATE_W'(1);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        prefer_cpu <= DSP_ACK;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        DACD <= mem[rd_ptr];
      end
      DACWRL <= !pop;
      UNDERRUN <= (tick && count == '0) || (UNDERRUN && !UNDERRUN_CLR);
    end
  end
  always_ff @(posedge XCK)
    if (push) mem[wr_ptr] <= push_d;
endmodule

// File: tb/tb_dac_sample_sequencer.sv
// tb_dac_sample_sequencer: scoreboard bench for dac_sample_sequencer
module tb_dac_sample_sequencer;
  logic XCK = 0, RESET = 1, EN = 0, DSP_WR = 0, CPU_WR = 0, UNDERRUN_CLR = 0;
  logic [11:0] RATE = 12'd3;
  logic [15:0] DSP_D = '0, CPU_D = '0;
  logic DSP_ACK, CPU_ACK, FULL, EMPTY, UNDERRUN, DACWRL;
  logic [15:0] DACD;
  int checks = 0, failures = 0;
  logic [15:0] q[$];
  dac_sample_sequencer #(.DEPTH(4), .RATE_W(12)) dut (
    .XCK(XCK), .RESET(RESET), .EN(EN), .RATE(RATE),
    .DSP_WR(DSP_WR), .DSP_D(DSP_D), .DSP_ACK(DSP_ACK),
    .CPU_WR(CPU_WR), .CPU_D(CPU_D), .CPU_ACK(CPU_ACK),
    .FULL(FULL), .EMPTY(EMPTY), .UNDERRUN(UNDERRUN), .UNDERRUN_CLR(UNDERRUN_CLR),
    .DACWRL(DACWRL), .DACD(DACD)
  );
  always #5 XCK = ~XCK;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge XCK)
    if (DACWRL === 1'b0) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL strobe: got unexpected strobe data %h expected no strobe", DACD);
      end else chk("strobe", DACD, q.pop_front());
    end
  task automatic do_reset(input logic en, input logic [11:0] r);
    RESET = 1; EN = en; RATE = r; DSP_WR = 0; CPU_WR = 0; UNDERRUN_CLR = 0;
    repeat (2) @(negedge XCK);
    q.delete();
    RESET = 0;
  endtask
  task automatic push_dsp(input logic [15:0] d);
    DSP_WR = 1; DSP_D = d;
    #1 chk("dsp_ack", 16'(DSP_ACK), 16'd1);
    q.push_back(d);
    @(negedge XCK);
    DSP_WR = 0;
  endtask
  task automatic drain(input int n);
    int i = 0;
    while (q.size() != 0 && i < n) begin
      @(negedge XCK);
      i++;
    end
    chk("drain", 16'(q.size()), 16'd0);
    repeat (2) @(negedge XCK);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    do_reset(1, 3);
    chk("rst_wrl", 16'(DACWRL), 16'd1);
    chk("rst_dacd", DACD, 16'h0000);
    chk("rst_empty", 16'(EMPTY), 16'd1);
    chk("rst_full", 16'(FULL), 16'd0);
    chk("rst_underrun", 16'(UNDERRUN), 16'd0);
    repeat (3) @(negedge XCK);
    chk("ur_before", 16'(UNDERRUN), 16'd0);
    @(negedge XCK);
    chk("ur_set", 16'(UNDERRUN), 16'd1);
    chk("ur_dacd", DACD, 16'h0000);
    UNDERRUN_CLR = 1;
    @(negedge XCK);
    UNDERRUN_CLR = 0;
    chk("ur_clr", 16'(UNDERRUN), 16'd0);
    do_reset(0, 3);
    push_dsp(16'h1111);
    push_dsp(16'h2222);
    push_dsp(16'h3333);
    push_dsp(16'h4444);
    chk("fill_full", 16'(FULL), 16'd1);
    chk("fill_empty", 16'(EMPTY), 16'd0);
    DSP_WR = 1; DSP_D = 16'h5555; EN = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("held_ack", 16'(DSP_ACK), 16'(i == 4));
      if (i == 4) q.push_back(16'h5555);
      @(negedge XCK);
    end
    DSP_WR = 0;
    chk("refill_full", 16'(FULL), 16'd1);
    drain(40);
    EN = 0;
    do_reset(0, 3);
    DSP_WR = 1; DSP_D = 16'hA001; CPU_WR = 1; CPU_D = 16'hB001;
    #1 chk("rr0_dsp", 16'(DSP_ACK), 16'd1);
    chk("rr0_cpu", 16'(CPU_ACK), 16'd0);
    q.push_back(16'hA001);
    @(negedge XCK);
    DSP_D = 16'hA002;
    #1 chk("rr1_dsp", 16'(DSP_ACK), 16'd0);
    chk("rr1_cpu", 16'(CPU_ACK), 16'd1);
    q.push_back(16'hB001);
    @(negedge XCK);
    CPU_D = 16'hB002;
    #1 chk("rr2_dsp", 16'(DSP_ACK), 16'd1);
    chk("rr2_cpu", 16'(CPU_ACK), 16'd0);
    q.push_back(16'hA002);
    @(negedge XCK);
    DSP_WR = 0;
    #1 chk("rr3_dsp", 16'(DSP_ACK), 16'd0);
    chk("rr3_cpu", 16'(CPU_ACK), 16'd1);
    q.push_back(16'hB002);
    @(negedge XCK);
    CPU_WR = 0;
    EN = 1;
    drain(40);
    EN = 0;
    do_reset(0, 0);
    push_dsp(16'h0C01);
    push_dsp(16'h0C02);
    push_dsp(16'h0C03);
    EN = 1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge XCK);
      chk("rate0_wrl", 16'(DACWRL), 16'(i == 4));
      if (i >= 3) chk("rate0_ur", 16'(UNDERRUN), 16'(i == 4));
    end
    EN = 0;
    do_reset(0, 3);
    push_dsp(16'hD001);
    push_dsp(16'hD002);
    push_dsp(16'hD003);
    push_dsp(16'hD004);
    CPU_WR = 1; CPU_D = 16'hC0FE; EN = 1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("tickfull_ack", 16'(CPU_ACK), 16'(i == 4));
      if (i == 4) begin
        q.push_back(16'hC0FE);
        chk("tickfull_notfull", 16'(FULL), 16'd0);
        EN = 0;
      end
      @(negedge XCK);
    end
    CPU_WR = 0;
    chk("tickfull_full", 16'(FULL), 16'd1);
    EN = 1;
    for (int i = 0; i < 20 && DACWRL !== 1'b0; i++) @(negedge XCK);
    chk("rst_strobe_seen", 16'(DACWRL), 16'd0);
    #1 RESET = 1;
    q.delete();
    @(negedge XCK);
    chk("midrst_wrl", 16'(DACWRL), 16'd1);
    chk("midrst_dacd", DACD, 16'h0000);
    chk("midrst_empty", 16'(EMPTY), 16'd1);
    chk("midrst_full", 16'(FULL), 16'd0);
    chk("midrst_ur", 16'(UNDERRUN), 16'd0);
    RESET = 0; EN = 0;
    repeat (2) @(negedge XCK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dac_sample_sequencer.md
Name: dac_sample_sequencer

Overview:
- Paced sample scheduler that feeds the PWM audio DAC.
- Two requesters push 16-bit two's-complement samples into a shared FIFO: DSP (port A) and CPU (port B).
- A programmable rate divider pops one sample per period and issues a single-cycle active-low DAC write strobe with the sample on the DAC data bus.
- It sits between the bus/DSP write decode and the PWM DAC load inputs, replacing direct unpaced DAC writes.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- RATE_W, 12, width of the sample-period register.

Ports:
- XCK  in  1  system clock; all logic on rising edge.
- RESET  in  1  synchronous reset, active-high.
- EN  in  1  enables the rate divider and strobe generation.
- RATE  in  RATE_W  sample period minus 1, in XCK cycles.
- DSP_WR  in  1  DSP push request; held until acknowledged.
- DSP_D  in  16  DSP sample.
- DSP_ACK  out  1  one-cycle pulse; DSP sample accepted this cycle.
- CPU_WR  in  1  CPU push request; held until acknowledged.
- CPU_D  in  16  CPU sample.
- CPU_ACK  out  1  one-cycle pulse; CPU sample accepted this cycle.
- FULL  out  1  FIFO count == DEPTH (registered).
- EMPTY  out  1  FIFO count == 0 (registered).
- UNDERRUN  out  1  sticky; a tick found the FIFO empty.
- UNDERRUN_CLR  in  1  clears UNDERRUN.
- DACWRL  out  1  active-low DAC load strobe.
- DACD  out  16  sample to the DAC, D_15..D_0 (D_1..D_0 unused by the DAC).

Behaviour:
- Reset values:
  - count, read pointer and write pointer 0; EMPTY=1, FULL=0.
  - DACWRL=1, DACD=16'h0000 (midscale, because the DAC inverts bit 15).
  - UNDERRUN=0, ACKs 0.
  - Rate counter loaded with RATE; round-robin pointer favours DSP.
- RESET mid-operation discards FIFO contents. A strobe in flight is forced high on the next edge.
- Push arbitration, evaluated each cycle from registered count:
  - A push is accepted only when count < DEPTH. There is no full-bypass, even if a pop occurs the same cycle.
  - At most one push per cycle.
  - One requester: it is granted.
  - Both requesting: round-robin. The requester not granted last time wins; the pointer updates only on a grant.
  - The granted ACK is high in the same cycle the data is written. The requester drops or changes WR/D on the next cycle.
  - A WR held while FULL gets no ACK and waits; there is no loss and no error.
- Rate divider:
  - EN=0: the counter is held at RATE and no ticks occur. The FIFO still accepts pushes.
  - EN=1: the counter decrements each cycle. At 0 it asserts tick and reloads RATE.
  - The first tick after EN rises comes RATE+1 cycles later. A RATE change takes effect at the next reload.
- Tick at cycle t with count > 0:
  - Head is popped at t.
  - At t+1: DACD = head and DACWRL = 0.
  - At t+2: DACWRL = 1 unless another tick popped at t+1 (RATE=0). DACD holds its value until the next pop.
- Tick with count == 0:
  - No pop; DACWRL stays 1 and DACD holds.
  - UNDERRUN is set at t+1.
  - A push in the same cycle is not bypassed.
- Simultaneous push and pop: count unchanged; pointers both advance and wrap modulo DEPTH.
- UNDERRUN_CLR and a new underrun in the same cycle: set wins.
- FULL and EMPTY update one cycle after the causing push or pop.
- Latency from push to strobe: at least 2 cycles. The data written is exactly the ACKed requester's D.

Test Plan:
- Reset, EN=1, RATE=3, no pushes -> DACWRL stays 1, DACD=0000; UNDERRUN=1 one cycle after the first tick at cycle 4; CLR then clears it.
- EN=0, DSP pushes 1111, 2222, 3333, 4444 -> four DSP_ACK pulses, FULL=1. A fifth push of 5555 is held with no ACK. EN=1, RATE=3 -> strobes every 4 cycles carrying 1111, 2222, 3333, 4444 in order; 5555 is ACKed the cycle after the first pop drops count below DEPTH, and its strobe follows the 4444 strobe.
- DSP_WR and CPU_WR held simultaneously from reset, data A001/B001 then A002/B002 -> grant order DSP, CPU, DSP, CPU; strobed sequence A001, B001, A002, B002.
- RATE=0, EN=1, 3 samples pre-loaded -> DACWRL low for 3 consecutive cycles with DACD stepping through the samples, then high; UNDERRUN sets on the 4th tick.
- Full FIFO, tick and pending CPU_WR in the same cycle -> pop occurs, CPU gets no ACK that cycle, ACK next cycle; count returns to DEPTH.
- RESET asserted the cycle DACWRL=0 -> next cycle DACWRL=1, DACD=0000, EMPTY=1, UNDERRUN=0.
